// File: rtl/tx_scheduler_pkg.sv
// Shared constants for the transmitter-side blocks: scheduler state encoding
// and the default frame-length / watchdog widths.
package tx_scheduler_pkg;

    localparam int NTW_DEFAULT = 8;
    localparam int WDW_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_SEND    = 2'd2,
        ST_RELEASE = 2'd3
    } tx_state_e;

    // Index width for N requesters, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_scheduler_rr_arbiter.sv
// Round-robin winner selection: the first requester at or after ptr wins.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter
    import tx_scheduler_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx
);

    int            cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        valid    = 1'b0;
        win_oh   = '0;
        win_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < N; i++) begin
            cand     = (int'(ptr) + i) % N;
            cand_idx = IW'(cand);
            if (!valid && req[cand_idx]) begin
                valid            = 1'b1;
                win_idx          = cand_idx;
                win_oh[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_scheduler.sv
// Shares one serial transmitter among N requesters: round-robin grant,
// frame-length hand-off, watchdog on the transmit phase, ack/err pulses.
module tx_scheduler
    import tx_scheduler_pkg::*;
#(
    parameter int N   = 4,
    parameter int NTW = NTW_DEFAULT,
    parameter int WDW = WDW_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   ser_in,
    input  logic [N*NTW-1:0] nt_in,
    input  logic           tx_done,
    output logic           tx_en,
    output logic [NTW-1:0] tx_nt,
    output logic           tx_ser,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   ack,
    output logic [N-1:0]   err,
    output logic           busy,
    output logic [1:0]     state_dbg
);

    localparam int IW = idx_width(N);
    // Last watchdog value still allowed in SEND; expiry lands on 2^WDW-1 cycles.
    localparam logic [WDW-1:0] WD_LAST = {{(WDW-1){1'b1}}, 1'b0};

    // Handshake: a requester raises req and holds it until it sees ack or err
    // (one-cycle pulses in the RELEASE cycle); gnt marks the transfer owner.
    // Dropping req while owning the transmitter aborts the frame silently.

    tx_state_e      state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  win_idx_q, win_idx_d;
    logic [N-1:0]   win_oh_q, win_oh_d;
    logic [NTW-1:0] tx_nt_q, tx_nt_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic [N-1:0]   ack_q, ack_d;
    logic [N-1:0]   err_q, err_d;

    logic           arb_valid;
    logic [N-1:0]   arb_oh;
    logic [IW-1:0]  arb_idx;
    logic [NTW-1:0] nt_sel;
    logic           win_req;

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .valid   (arb_valid),
        .win_oh  (arb_oh),
        .win_idx (arb_idx)
    );

    always_comb begin
        nt_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (arb_oh[i]) begin
                nt_sel = nt_in[i*NTW +: NTW];
            end
        end
    end

    assign win_req = |(req & win_oh_q);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        win_oh_d  = win_oh_q;
        tx_nt_d   = tx_nt_q;
        wd_d      = '0;
        ack_d     = '0;
        err_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    state_d   = ST_GRANT;
                    win_idx_d = arb_idx;
                    win_oh_d  = arb_oh;
                    tx_nt_d   = nt_sel;
                end
            end
            ST_GRANT: begin
                if (tx_nt_q == '0) begin
                    err_d   = win_oh_q;
                    state_d = ST_RELEASE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                wd_d = wd_q + 1'b1;
                // Completion outranks both abort and watchdog expiry.
                if (tx_done) begin
                    ack_d   = win_oh_q;
                    state_d = ST_RELEASE;
                end else if (!win_req) begin
                    state_d = ST_RELEASE;
                end else if (wd_q == WD_LAST) begin
                    err_d   = win_oh_q;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                ptr_d   = (win_idx_q == IW'(N - 1)) ? '0 : win_idx_q + 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            win_idx_q <= '0;
            win_oh_q  <= '0;
            tx_nt_q   <= '0;
            wd_q      <= '0;
            ack_q     <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_idx_q <= win_idx_d;
            win_oh_q  <= win_oh_d;
            tx_nt_q   <= tx_nt_d;
            wd_q      <= wd_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign gnt       = ((state_q == ST_GRANT) || (state_q == ST_SEND)) ? win_oh_q : '0;
    assign tx_en     = (state_q == ST_SEND);
    assign tx_nt     = tx_nt_q;
    assign tx_ser    = |(ser_in & gnt);
    assign ack       = ack_q;
    assign err       = err_q;
    assign busy      = (state_q != ST_IDLE);
    assign state_dbg = state_q;

    ack_err_excl: assert property (@(posedge clk) disable iff (rst) !((|ack) && (|err)));
    ack_err_oh:   assert property (@(posedge clk) disable iff (rst) $onehot0(ack) && $onehot0(err));

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 Parameter N, default 4, number of requesters sharing one serial transmitter.
REQ-002 Parameter NTW, default 8, width of frame-length field (matches transmitter nt).
REQ-003 Parameter WDW, default 10, width of watchdog counter.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  N  per-requester transfer request, level, held until ack/err.
REQ-007 ser_in  input  N  per-requester serial data bit.
REQ-008 nt_in  input  N*NTW  per-requester frame length, slice i = nt_in[i*NTW +: NTW].
REQ-009 tx_done  input  1  done (counter carry) from shared transmitter.
REQ-010 tx_en  output  1  enable to shared transmitter.
REQ-011 tx_nt  output  NTW  frame length driven to transmitter, registered.
REQ-012 tx_ser  output  1  serial data muxed from granted requester.
REQ-013 gnt  output  N  one-hot grant, all-zero when idle.
REQ-014 ack  output  N  one-cycle completion pulse to served requester.
REQ-015 err  output  N  one-cycle error pulse (zero length or watchdog timeout).
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 FSM states SHALL be IDLE, GRANT, SEND, RELEASE; encoding 2 bits.
REQ-018 IDLE: if any req bit high, SHALL select winner by round-robin, starting at index after last served (index 0 after reset), go GRANT next cycle.
REQ-019 GRANT (1 cycle): gnt one-hot of winner, tx_nt latched from winner slice, tx_en low; if latched nt == 0, SHALL pulse err[winner] and go RELEASE, else go SEND.
REQ-020 SEND: tx_en high, tx_ser = ser_in[winner] combinationally; tx_nt and gnt held constant.
REQ-021 SEND: tx_done high SHALL cause RELEASE next cycle with ack[winner] pulsed in that RELEASE cycle.
REQ-022 Latency: req rising in IDLE at edge k -> gnt at k+1 -> tx_en high at k+2.
REQ-023 RELEASE (1 cycle): tx_en low, gnt zero, pointer updated to winner+1 mod N, then IDLE; guarantees at least two tx_en-low cycles between frames so transmitter counter resets.
REQ-024 Watchdog counts SEND cycles; on reaching 2^WDW-1 without tx_done SHALL pulse err[winner], no ack, go RELEASE.
REQ-025 Requester dropping req during SEND SHALL abort: RELEASE next cycle, no ack, no err.
REQ-026 tx_done simultaneous with req drop or watchdog expiry: tx_done wins, ack pulsed.
REQ-027 tx_done outside SEND SHALL be ignored.
REQ-028 req changes of non-granted requesters SHALL not affect the current transfer.
REQ-029 ack and err SHALL never be high in the same cycle, and at most one bit of each is set.

Reset
REQ-030 rst high at a rising edge SHALL force IDLE, pointer 0, watchdog 0, tx_nt 0, and tx_en, gnt, ack, err, busy low from the next cycle, including mid-SEND.
REQ-031 tx_ser SHALL be 0 whenever gnt is zero.

Structure
REQ-032 State encodings and the default NTW/WDW values SHALL live in a shared constants include used by transmitter-side blocks.
REQ-033 Winner selection SHALL be one sub-module rr_arbiter (inputs req, pointer; output one-hot winner and index); FSM, watchdog and mux in tx_scheduler.

Verification
REQ-034 Single req[1], nt=5, tx_done pulsed 5 cycles after tx_en rises -> gnt=0010 at k+1, tx_en at k+2, ack=0010 one cycle after done, busy low two cycles after done.
REQ-035 req=1111 held, each done after nt=3 -> grant order 0,1,2,3,0 with RELEASE and IDLE cycles between frames.
REQ-036 req[2] with nt=0 -> err=0100 pulse in RELEASE, tx_en never high.
REQ-037 req[0], tx_done never asserted, WDW=4 -> err=0001 after 15 SEND cycles, tx_en low next cycle.
REQ-038 rst asserted third cycle of SEND -> all outputs low next cycle, next grant goes to index 0.
REQ-039 req[3] dropped mid-SEND while req[0] high -> no ack/err for 3, next grant to 0.
